// File: rtl/lvt_multiread_table_pkg.sv
// Shared types and helpers for the live value table.
// Optional write-first read bypass is enabled by defining LVT_BYPASS_EN.
package lvt_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } lvt_state_e;

    localparam int LVT_P_DEF           = 4;
    localparam int LVT_Q_DEF           = 4;
    localparam int LVT_INDEX_WIDTH_DEF = 8;

    function automatic int lvt_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Low bit of a port's field inside a flat packed bus.
    function automatic int lvt_slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/lvt_multiread_table_wr_prio_enc.sv
// Write-port priority encoder: the highest-index enabled writer to an
// address wins, lower-index writers to the same address are suppressed.
module lvt_wr_prio_enc
    import lvt_pkg::*;
#(
    parameter int P           = LVT_P_DEF,
    parameter int INDEX_WIDTH = LVT_INDEX_WIDTH_DEF
) (
    input  logic [P*INDEX_WIDTH-1:0] addr,
    input  logic [P-1:0]             en,
    output logic [P-1:0]             eff_en,
    output logic                     conflict
);

    always_comb begin
        eff_en   = en;
        conflict = 1'b0;
        for (int i = 0; i < P; i++) begin
            for (int k = i + 1; k < P; k++) begin
                if (en[i] && en[k] &&
                    addr[lvt_slice_lo(i, INDEX_WIDTH) +: INDEX_WIDTH] ==
                    addr[lvt_slice_lo(k, INDEX_WIDTH) +: INDEX_WIDTH]) begin
                    eff_en[i] = 1'b0;
                    conflict  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lvt_multiread_table.sv
// Live value table for P-write/Q-read replicated-bank memories, with a
// post-reset clearing sweep. Define LVT_BYPASS_EN for write-first reads.
module lvt_multiread_table
    import lvt_pkg::*;
#(
    parameter int P           = LVT_P_DEF,
    parameter int Q           = LVT_Q_DEF,
    parameter int INDEX_WIDTH = LVT_INDEX_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [P*INDEX_WIDTH-1:0]      write_addr,
    input  logic [P-1:0]                  w_en,
    input  logic [Q*INDEX_WIDTH-1:0]      read_addr,
    input  logic [Q-1:0]                  r_en,
    output logic [Q*lvt_clog2(P)-1:0]     lvt_sel,
    output logic [Q-1:0]                  rd_valid,
    output logic                          init_busy,
    output logic                          wr_conflict
);

    localparam int N_PE_BITS = lvt_clog2(P);
    localparam int DEPTH     = 1 << INDEX_WIDTH;

    lvt_state_e                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]      cnt_q, cnt_d;
    logic [N_PE_BITS-1:0]        table_q [DEPTH];
    logic [N_PE_BITS-1:0]        table_d [DEPTH];
    logic [Q*N_PE_BITS-1:0]      lvt_sel_q, lvt_sel_d;
    logic [Q-1:0]                rd_valid_q, rd_valid_d;
    logic                        wr_conflict_q, wr_conflict_d;
    logic                        run;
    logic [P-1:0]                run_w_en;
    logic [P-1:0]                eff_w_en;
    logic                        conflict;

    assign run      = (state_q == RUN);
    assign run_w_en = run ? w_en : '0;

    lvt_wr_prio_enc #(
        .P           (P),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_wr_prio_enc (
        .addr     (write_addr),
        .en       (run_w_en),
        .eff_en   (eff_w_en),
        .conflict (conflict)
    );

    // The sweep clears one entry per cycle and hands over to RUN once the last entry is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        table_d = table_q;
        if (state_q == INIT) begin
            table_d[cnt_q] = '0;
        end else begin
            for (int i = 0; i < P; i++) begin
                if (eff_w_en[i]) begin
                    table_d[write_addr[lvt_slice_lo(i, INDEX_WIDTH) +: INDEX_WIDTH]] = N_PE_BITS'(i);
                end
            end
        end
    end

    always_comb begin
        logic [INDEX_WIDTH-1:0] rd_addr;
        logic [N_PE_BITS-1:0]   sel;
        rd_addr       = '0;
        sel           = '0;
        lvt_sel_d     = lvt_sel_q;
        rd_valid_d    = '0;
        wr_conflict_d = conflict;
        if (run) begin
            for (int j = 0; j < Q; j++) begin
                if (r_en[j]) begin
                    rd_addr = read_addr[lvt_slice_lo(j, INDEX_WIDTH) +: INDEX_WIDTH];
                    sel     = table_q[rd_addr];
`ifdef LVT_BYPASS_EN
                    for (int i = 0; i < P; i++) begin
                        if (eff_w_en[i] &&
                            write_addr[lvt_slice_lo(i, INDEX_WIDTH) +: INDEX_WIDTH] == rd_addr) begin
                            sel = N_PE_BITS'(i);
                        end
                    end
`endif
                    lvt_sel_d[lvt_slice_lo(j, N_PE_BITS) +: N_PE_BITS] = sel;
                    rd_valid_d[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            lvt_sel_q     <= '0;
            rd_valid_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lvt_sel_q     <= lvt_sel_d;
            rd_valid_q    <= rd_valid_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Table contents are deliberately not reset; the sweep clears them instead.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign lvt_sel     = lvt_sel_q;
    assign rd_valid    = rd_valid_q;
    assign wr_conflict = wr_conflict_q;
    assign init_busy   = (state_q == INIT);

endmodule
